// File: rtl/escritor_filas_memoria_pkg.sv
// -----------------------------------------------------------------------------
// escritor_filas_memoria_pkg
// Shared definitions for the row writer: FSM state encoding and the pixel/word
// geometry used by both the top level and the pixel packer.
// -----------------------------------------------------------------------------
package escritor_filas_memoria_pkg;

    localparam int BITS_PIXEL          = 8;
    localparam int BITS_PALABRA        = 64;
    localparam int PIXELES_POR_PALABRA = 8;
    localparam int BITS_INDICE         = $clog2(PIXELES_POR_PALABRA);

    typedef enum logic [1:0] {
        REPOSO      = 2'd0,
        LLENANDO    = 2'd1,
        ESCRIBIENDO = 2'd2,
        TERMINADO   = 2'd3
    } estado_t;

endpackage

// File: rtl/escritor_filas_memoria_empaquetador_pixeles.sv
// -----------------------------------------------------------------------------
// empaquetador_pixeles
// Packs consecutive 8-bit pixels into one 64-bit word, first pixel in the LSB
// byte.
//   clk      in   clock
//   reset    in   synchronous, active-low reset
//   limpiar  in   clear index and word (start of a frame)
//   cargar   in   store pixel at the current index and advance the index
//   pixel    in   pixel data
//   palabra  out  packed word (held while cargar is low)
//   ultimo   out  current index is the last byte lane
// -----------------------------------------------------------------------------
module empaquetador_pixeles
    import escritor_filas_memoria_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    limpiar,
    input  logic                    cargar,
    input  logic [BITS_PIXEL-1:0]   pixel,
    output logic [BITS_PALABRA-1:0] palabra,
    output logic                    ultimo
);

    localparam logic [BITS_INDICE-1:0] ULTIMO_INDICE = BITS_INDICE'(PIXELES_POR_PALABRA - 1);

    logic [BITS_INDICE-1:0]         r_indice;
    logic [BITS_PALABRA-1:0]        r_palabra;
    logic [PIXELES_POR_PALABRA-1:0] w_sel_carril;

    // One-hot byte-lane select decoded from the index.
    for (genvar gi = 0; gi < PIXELES_POR_PALABRA; gi++) begin : g_sel_carril
        assign w_sel_carril[gi] = cargar && (r_indice == BITS_INDICE'(gi));
    end

    // The index wraps naturally from 7 to 0 after the last lane is loaded.
    always_ff @(posedge clk) begin
        if (!reset || limpiar) begin
            r_indice <= '0;
        end else if (cargar) begin
            r_indice <= r_indice + BITS_INDICE'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || limpiar) begin
            r_palabra <= '0;
        end else begin
            for (int i = 0; i < PIXELES_POR_PALABRA; i++) begin
                if (w_sel_carril[i]) begin
                    r_palabra[i*BITS_PIXEL +: BITS_PIXEL] <= pixel;
                end
            end
        end
    end

    assign palabra = r_palabra;
    assign ultimo  = (r_indice == ULTIMO_INDICE);

endmodule

// File: rtl/escritor_filas_memoria.sv
// -----------------------------------------------------------------------------
// escritor_filas_memoria
// Receives processed pixels over a valid/ready handshake, packs eight per
// 64-bit word and writes each word to image memory at base_fila + columna,
// moving the row base by PALABRAS_POR_FILA after each full row.
//   clk            in   clock
//   reset          in   synchronous, active-low reset
//   iniciar        in   start pulse (only honoured when idle)
//   pixel_entrada  in   pixel data
//   pixel_valido   in   pixel_entrada valid
//   pixel_listo    out  ready to accept a pixel
//   escribir       out  memory write request
//   direccion      out  word write address
//   datos_salida   out  packed word
//   memoria_lista  in   memory accepts the write this cycle
//   ocupado        out  not idle
//   terminado      out  one-cycle frame completion pulse
// -----------------------------------------------------------------------------
module escritor_filas_memoria
    import escritor_filas_memoria_pkg::*;
#(
    parameter int DIRECCION_INICIO  = 0,
    parameter int BITS_DIRECCION    = 11,
    parameter int PALABRAS_POR_FILA = 16,
    parameter int CANTIDAD_FILAS    = 128
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      iniciar,
    input  logic [BITS_PIXEL-1:0]     pixel_entrada,
    input  logic                      pixel_valido,
    output logic                      pixel_listo,
    output logic                      escribir,
    output logic [BITS_DIRECCION-1:0] direccion,
    output logic [BITS_PALABRA-1:0]   datos_salida,
    input  logic                      memoria_lista,
    output logic                      ocupado,
    output logic                      terminado
);

    localparam int BITS_COLUMNA = (PALABRAS_POR_FILA > 1) ? $clog2(PALABRAS_POR_FILA) : 1;
    localparam int BITS_FILA    = (CANTIDAD_FILAS > 1) ? $clog2(CANTIDAD_FILAS) : 1;

    localparam logic [BITS_COLUMNA-1:0]   ULTIMA_COLUMNA = BITS_COLUMNA'(PALABRAS_POR_FILA - 1);
    localparam logic [BITS_FILA-1:0]      ULTIMA_FILA    = BITS_FILA'(CANTIDAD_FILAS - 1);
    localparam logic [BITS_DIRECCION-1:0] BASE_INICIAL   = BITS_DIRECCION'(DIRECCION_INICIO);
    localparam logic [BITS_DIRECCION-1:0] PASO_FILA      = BITS_DIRECCION'(PALABRAS_POR_FILA);

    estado_t                   r_estado;
    estado_t                   w_estado_next;
    logic [BITS_COLUMNA-1:0]   r_columna;
    logic [BITS_FILA-1:0]      r_fila;
    logic [BITS_DIRECCION-1:0] r_base_fila;

    logic w_arrancar;
    logic w_acepta_pixel;
    logic w_palabra_aceptada;
    logic w_ultima_columna;
    logic w_ultima_palabra;
    logic w_ultimo_pixel;

    assign w_arrancar         = (r_estado == REPOSO) && iniciar;
    assign w_acepta_pixel     = (r_estado == LLENANDO) && pixel_valido;
    assign w_palabra_aceptada = (r_estado == ESCRIBIENDO) && memoria_lista;
    assign w_ultima_columna   = (r_columna == ULTIMA_COLUMNA);
    assign w_ultima_palabra   = w_ultima_columna && (r_fila == ULTIMA_FILA);

    empaquetador_pixeles u_empaquetador (
        .clk     (clk),
        .reset   (reset),
        .limpiar (w_arrancar),
        .cargar  (w_acepta_pixel),
        .pixel   (pixel_entrada),
        .palabra (datos_salida),
        .ultimo  (w_ultimo_pixel)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_estado <= REPOSO;
        end else begin
            r_estado <= w_estado_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_estado_next = r_estado;
        unique case (r_estado)
            REPOSO:      if (iniciar) w_estado_next = LLENANDO;
            LLENANDO:    if (w_acepta_pixel && w_ultimo_pixel) w_estado_next = ESCRIBIENDO;
            ESCRIBIENDO: if (memoria_lista) w_estado_next = w_ultima_palabra ? TERMINADO : LLENANDO;
            TERMINADO:   w_estado_next = REPOSO;
            default:     w_estado_next = REPOSO;
        endcase
    end

    // Outputs decoded from the registered state only.
    always_comb begin
        pixel_listo = (r_estado == LLENANDO);
        escribir    = (r_estado == ESCRIBIENDO);
        ocupado     = (r_estado != REPOSO);
        terminado   = (r_estado == TERMINADO);
    end

    // Column/row counters and row base; only move when memory takes a word,
    // so the address stays frozen for the whole write.
    always_ff @(posedge clk) begin
        if (!reset || w_arrancar) begin
            r_columna   <= '0;
            r_fila      <= '0;
            r_base_fila <= BASE_INICIAL;
        end else if (w_palabra_aceptada) begin
            if (w_ultima_columna) begin
                r_columna   <= '0;
                r_fila      <= r_fila + BITS_FILA'(1);
                r_base_fila <= r_base_fila + PASO_FILA;
            end else begin
                r_columna   <= r_columna + BITS_COLUMNA'(1);
            end
        end
    end

    // Modulo-2^BITS_DIRECCION sum.
    assign direccion = r_base_fila + BITS_DIRECCION'(r_columna);

endmodule

// File: tb/tb_escritor_filas_memoria.sv
module tb_escritor_filas_memoria;

    logic        clk = 1'b0;
    logic        reset;
    logic        iniciar;
    logic [7:0]  pixel_entrada;
    logic        pixel_valido;
    logic        pixel_listo;
    logic        escribir;
    logic [10:0] direccion;
    logic [63:0] datos_salida;
    logic        memoria_lista;
    logic        ocupado;
    logic        terminado;

    int n_checks = 0;
    int n_fallos = 0;

    always #5 clk = ~clk;

    escritor_filas_memoria #(
        .DIRECCION_INICIO  (0),
        .BITS_DIRECCION    (11),
        .PALABRAS_POR_FILA (16),
        .CANTIDAD_FILAS    (128)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .iniciar       (iniciar),
        .pixel_entrada (pixel_entrada),
        .pixel_valido  (pixel_valido),
        .pixel_listo   (pixel_listo),
        .escribir      (escribir),
        .direccion     (direccion),
        .datos_salida  (datos_salida),
        .memoria_lista (memoria_lista),
        .ocupado       (ocupado),
        .terminado     (terminado)
    );

    typedef struct {
        logic [7:0]  base;
        int          alternar;
        int          espera;
        logic [10:0] dir;
        logic [63:0] datos;
    } vector_t;

    vector_t tabla [4];

    task automatic chk(input string nombre, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fallos++;
            $display("FAIL %s: got %h expected %h", nombre, got, exp);
        end
    endtask

    function automatic logic [63:0] datos_esperados(input logic [7:0] base);
        logic [63:0] d;
        for (int k = 0; k < 8; k++) d[8*k +: 8] = base + 8'(k);
        return d;
    endfunction

    task automatic arrancar();
        @(negedge clk);
        iniciar = 1'b1;
        pixel_valido = 1'b0;
        @(negedge clk);
        iniciar = 1'b0;
        chk("arranque_ocupado", 64'(ocupado), 64'd1);
        chk("arranque_pixel_listo", 64'(pixel_listo), 64'd1);
    endtask

    // Offers eight pixels base..base+7; with alternar the valid line toggles 1/0.
    task automatic enviar_pixeles(input logic [7:0] base, input int alternar, input string nombre);
        int  enviados = 0;
        int  ciclos = 0;
        bit  hueco = 1'b0;
        while (enviados < 8 && ciclos < 64) begin
            @(negedge clk);
            if (alternar != 0 && hueco) begin
                pixel_valido  = 1'b0;
                pixel_entrada = 8'h5A;
            end else begin
                pixel_valido  = 1'b1;
                pixel_entrada = base + 8'(enviados);
                if (pixel_listo) enviados++;
            end
            hueco = !hueco;
            ciclos++;
        end
        chk({nombre, "_pixeles"}, 64'(enviados), 64'd8);
    endtask

    task automatic enviar_palabra(input logic [7:0] base, input int alternar, input int espera,
                                  input logic [10:0] exp_dir, input logic [63:0] exp_datos,
                                  input string nombre);
        enviar_pixeles(base, alternar, nombre);
        for (int s = 0; s <= espera; s++) begin
            @(negedge clk);
            // valid held high while writing must not be consumed
            pixel_valido  = 1'b1;
            pixel_entrada = 8'hEE;
            chk({nombre, "_escribir"}, 64'(escribir), 64'd1);
            chk({nombre, "_direccion"}, 64'(direccion), 64'(exp_dir));
            chk({nombre, "_datos"}, datos_salida, exp_datos);
            chk({nombre, "_pixel_listo"}, 64'(pixel_listo), 64'd0);
            memoria_lista = (s == espera);
        end
    endtask

    initial begin
        tabla[0] = '{8'h00, 0, 0, 11'd0, 64'h0706050403020100};
        tabla[1] = '{8'h10, 0, 5, 11'd1, 64'h1716151413121110};
        tabla[2] = '{8'hF8, 1, 0, 11'd2, 64'hFFFEFDFCFBFAF9F8};
        tabla[3] = '{8'hA0, 1, 2, 11'd3, 64'hA7A6A5A4A3A2A1A0};

        reset = 1'b0;
        iniciar = 1'b0;
        pixel_entrada = 8'h00;
        pixel_valido = 1'b0;
        memoria_lista = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_pixel_listo", 64'(pixel_listo), 64'd0);
        chk("reset_escribir", 64'(escribir), 64'd0);
        chk("reset_ocupado", 64'(ocupado), 64'd0);
        chk("reset_terminado", 64'(terminado), 64'd0);
        chk("reset_direccion", 64'(direccion), 64'd0);
        chk("reset_datos", datos_salida, 64'd0);
        $display("reset: outputs checked");
        reset = 1'b1;

        // Full frame: table words first, then the rest of the 2048 words.
        arrancar();
        for (int i = 0; i < 4; i++) begin
            enviar_palabra(tabla[i].base, tabla[i].alternar, tabla[i].espera,
                           tabla[i].dir, tabla[i].datos, $sformatf("vec%0d", i));
            $display("vec%0d: base=%h gaps=%0d stall=%0d dir=%0d datos=%h", i,
                     tabla[i].base, tabla[i].alternar, tabla[i].espera, tabla[i].dir, tabla[i].datos);
        end
        for (int w = 4; w < 2048; w++) begin
            enviar_palabra(8'(w * 3), 0, 0, 11'(w), datos_esperados(8'(w * 3)),
                           $sformatf("palabra%0d", w));
            if (w == 16 || w == 2047)
                $display("palabra%0d: dir=%0d datos=%h", w, direccion, datos_salida);
        end

        // Completion pulse; iniciar during terminado must be ignored.
        @(negedge clk);
        chk("fin_terminado", 64'(terminado), 64'd1);
        chk("fin_ocupado", 64'(ocupado), 64'd1);
        chk("fin_escribir", 64'(escribir), 64'd0);
        chk("fin_pixel_listo", 64'(pixel_listo), 64'd0);
        iniciar = 1'b1;
        pixel_valido = 1'b0;
        @(negedge clk);
        iniciar = 1'b0;
        chk("fin_terminado_un_ciclo", 64'(terminado), 64'd0);
        chk("fin_ocupado_bajo", 64'(ocupado), 64'd0);
        @(negedge clk);
        chk("iniciar_ignorado", 64'(ocupado), 64'd0);
        $display("frame: terminado pulse and idle checked");

        // Restart at address 0, then reset while word 3 is pending.
        arrancar();
        enviar_palabra(8'h33, 0, 0, 11'd0, 64'h3A39383736353433, "reinicio0");
        enviar_palabra(8'h40, 0, 0, 11'd1, 64'h4746454443424140, "reinicio1");
        enviar_palabra(8'h50, 0, 0, 11'd2, 64'h5756555453525150, "reinicio2");
        $display("restart: first words at 0..2 checked");
        enviar_pixeles(8'h60, 0, "abortada");
        @(negedge clk);
        pixel_valido = 1'b0;
        memoria_lista = 1'b0;
        chk("abortada_escribir", 64'(escribir), 64'd1);
        chk("abortada_direccion", 64'(direccion), 64'd3);
        reset = 1'b0;
        @(negedge clk);
        chk("abortada_escribir_bajo", 64'(escribir), 64'd0);
        chk("abortada_ocupado", 64'(ocupado), 64'd0);
        chk("abortada_datos", datos_salida, 64'd0);
        chk("abortada_direccion_cero", 64'(direccion), 64'd0);
        reset = 1'b1;
        memoria_lista = 1'b1;
        $display("abort: reset during write checked");

        arrancar();
        enviar_palabra(8'h80, 0, 0, 11'd0, 64'h8786858483828180, "tras_reset");
        $display("after reset: first word at 0 checked");
        @(negedge clk);
        pixel_valido = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fallos);
        $finish;
    end

endmodule
